alu_mul_sequencer: RTL and testbench
====================================

// Module: alu_mul_sequencer
// PURPOSE
// - Multi-cycle controller that runs an unsigned (optionally signed) WIDTH x WIDTH multiply.
// - Uses shift-add and borrows the execute-stage ALU for every partial-sum add.
// - Sits beside the ALU in execute-memory; owns the ALU operand/opcode bus while busy.
// - The stall/forwarding logic gates it through o_busy.
// PARAMETERS
// - WIDTH  16  operand width; product is 2*WIDTH; legal range 2..32
// PORTS
// - i_clk           in   1        clock; all state updates on rising edge
// - i_reset         in   1        synchronous, active-high reset
// - i_start         in   1        request; sampled only in IDLE or DONE
// - i_multiplicand  in   WIDTH    operand A, captured on the accepted start
// - i_multiplier    in   WIDTH    operand B, captured on the accepted start
// - i_signed        in   1        two's-complement mode; port exists only with MUL_SIGNED_EN
// - o_busy          out  1        high in ADD/SHIFT/NEG
// - o_done          out  1        one-cycle pulse; o_product valid that cycle
// - o_product       out  2*WIDTH  result; held until the next accepted start
// - o_alu_op        out  3        ALU opcode: 3'b000 NOP when not adding, 3'b010 ADD in ADD state
// - o_alu_data_1    out  WIDTH    acc_hi in ADD state, else 0
// - o_alu_data_2    out  WIDTH    (mplr_lo[0] ? mcand : 0) in ADD state, else 0
// - i_alu_result    in   WIDTH    ALU sum, combinational, same cycle
// - i_alu_carry     in   1        ALU carry-out of the ADD, same cycle
// BEHAVIOUR
// - Reset, synchronous: state=IDLE, o_busy=0, o_done=0, o_product=0, o_alu_op=000, operand outputs 0.
// - Reset has priority over everything. Mid-operation it aborts the multiply, no o_done.
// - Registers: mcand[W], acc_hi[W], mplr_lo[W], carry[1], cnt[$clog2(WIDTH)+1].
// - States: IDLE, ADD, SHIFT, NEG (signed build only), DONE.
// - IDLE or DONE with i_start=1 -> ADD:
//   - mcand<=A, mplr_lo<=B, acc_hi<=0, cnt<=0.
//   - Signed build with i_signed=1: load |A| and |B|; latch neg_flag = A[W-1]^B[W-1].
// - IDLE or DONE with i_start=0: DONE -> IDLE, IDLE stays IDLE.
// - ADD (1 cycle): drive the ALU as above; acc_hi<=i_alu_result, carry<=i_alu_carry -> SHIFT.
//   - The add is always issued; a zero addend when the bit is clear keeps latency data-independent.
// - SHIFT (1 cycle): {carry,acc_hi,mplr_lo} >>= 1 (carry enters acc_hi MSB); cnt<=cnt+1.
//   - If cnt==WIDTH-1: -> NEG if signed build and i_signed latched 1, else -> DONE.
//   - Otherwise -> ADD.
// - NEG (1 cycle): if neg_flag, {acc_hi,mplr_lo} <= two's complement, computed locally, not on the ALU.
//   - Then -> DONE.
// - DONE (1 cycle): o_done=1, o_busy=0, o_product={acc_hi,mplr_lo}, registered on entry.
// - Latency: start sampled at edge 0 -> o_done high during cycle 2*WIDTH+1, or 2*WIDTH+2 with NEG.
//   - WIDTH=16: 33 cycles unsigned, 34 cycles signed.
// - i_start while busy is ignored, no queueing. Operand inputs are don't-care except on the accepted edge.
// - Back-to-back: a start in DONE is accepted. Next o_done follows exactly one full latency later.
// - Arithmetic is modulo 2^WIDTH per add; the carry preserves the full 2*WIDTH result, so there is no overflow case.
// - Signed |x| of the most negative value equals 2^(W-1) as unsigned; the result is still exact.
// CONFIGURATION
// - MUL_SIGNED_EN defined:
//   - i_signed port and NEG state exist.
//   - Operands are sign-corrected on load; the result is negated in NEG when the operand signs differ.
// - MUL_SIGNED_EN undefined:
//   - No i_signed port and no NEG state; unsigned only.
//   - Latency is always 2*WIDTH+1.
// TESTING
// - T1: reset 2 cycles -> o_busy=0, o_done=0, o_product=0, o_alu_op=000.
// - T2: start A=3, B=5 -> o_busy for 32 cycles, o_done at cycle 33, o_product=32'h0000000F.
// - T3: start A=16'hFFFF, B=16'hFFFF -> o_product=32'hFFFE0001.
//   - Also check the ALU saw op 010 on every ADD cycle.
// - T4: start A=7, B=9; pulse start with A=1, B=1 at cycle 10.
//   - o_product=32'h0000003F; no second o_done.
// - T5: start A=100, B=200; i_reset at cycle 12 -> IDLE next cycle, no o_done.
//   - Fresh start A=2, B=3 -> o_product=6.
// - T6 (MUL_SIGNED_EN): i_signed=1, A=16'hFFFD (-3), B=5 -> o_done at cycle 34, o_product=32'hFFFFFFF1.
//   - Then start in the DONE cycle with A=16'h8000, B=16'h8000 -> o_product=32'h40000000.

Source files
------------

// File: rtl/alu_mul_sequencer.sv
// alu_mul_sequencer: multi-cycle shift-add multiplier that borrows the
// execute-stage ALU for every partial-sum add. One ADD/SHIFT pair is run per
// multiplier bit, so latency is fixed at 2*WIDTH+1 cycles from the accepted
// start to the o_done pulse.
//
// Optional feature: define MUL_SIGNED_EN to add the i_signed port and the NEG
// state (two's-complement multiply via magnitude multiply plus a final
// negation, 2*WIDTH+2 cycles when i_signed is set).
module alu_mul_sequencer #(
  parameter int WIDTH = 16
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_start,
  input  logic [WIDTH-1:0]     i_multiplicand,
  input  logic [WIDTH-1:0]     i_multiplier,
`ifdef MUL_SIGNED_EN
  input  logic                 i_signed,
`endif
  output logic                 o_busy,
  output logic                 o_done,
  output logic [2*WIDTH-1:0]   o_product,
  output logic [2:0]           o_alu_op,
  output logic [WIDTH-1:0]     o_alu_data_1,
  output logic [WIDTH-1:0]     o_alu_data_2,
  input  logic [WIDTH-1:0]     i_alu_result,
  input  logic                 i_alu_carry
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [2:0] ALU_NOP = 3'b000;
  localparam logic [2:0] ALU_ADD = 3'b010;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ADD   = 3'd1,
    S_SHIFT = 3'd2,
`ifdef MUL_SIGNED_EN
    S_NEG   = 3'd3,
`endif
    S_DONE  = 3'd4
  } state_t;

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     mcand_q, mcand_d;
  logic [WIDTH-1:0]     acc_hi_q, acc_hi_d;
  logic [WIDTH-1:0]     mplr_lo_q, mplr_lo_d;
  logic                 carry_q, carry_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   product_q, product_d;
`ifdef MUL_SIGNED_EN
  logic                 sgn_q, sgn_d;
  logic                 neg_q, neg_d;
  logic [2*WIDTH-1:0]   acc_neg;

  // Magnitude of a two's-complement operand; the most negative value maps to
  // 2^(WIDTH-1), which is still exact when read as unsigned.
  function automatic logic [WIDTH-1:0] abs_val(input logic [WIDTH-1:0] x);
    return x[WIDTH-1] ? (~x + 1'b1) : x;
  endfunction
`endif

  // State register and datapath registers; reset clears control and result.
  always_ff @(posedge i_clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (i_reset) begin
      state_q   <= S_IDLE;
      mcand_q   <= '0;
      acc_hi_q  <= '0;
      mplr_lo_q <= '0;
      carry_q   <= 1'b0;
      cnt_q     <= '0;
      product_q <= '0;
`ifdef MUL_SIGNED_EN
      sgn_q     <= 1'b0;
      neg_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      mcand_q   <= mcand_d;
      acc_hi_q  <= acc_hi_d;
      mplr_lo_q <= mplr_lo_d;
      carry_q   <= carry_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
`ifdef MUL_SIGNED_EN
      sgn_q     <= sgn_d;
      neg_q     <= neg_d;
`endif
    end
  end

  // ALU bus: kept separate from the next-state logic so the external
  // combinational ALU path (data out -> result in) is not a logic loop.
  always_comb begin
    o_alu_op     = ALU_NOP;
    o_alu_data_1 = '0;
    o_alu_data_2 = '0;
    if (state_q == S_ADD) begin
      o_alu_op     = ALU_ADD;
      o_alu_data_1 = acc_hi_q;
      // The add is issued even for a clear bit so latency never depends on data.
      o_alu_data_2 = mplr_lo_q[0] ? mcand_q : '0;
    end
  end

`ifdef MUL_SIGNED_EN
  assign acc_neg = ~{acc_hi_q, mplr_lo_q} + 1'b1;
`endif

  // Next-state and datapath update for the shift-add sequence.
  always_comb begin
    // NOTE: every target gets a default first so no path can infer a latch.
    state_d   = state_q;
    mcand_d   = mcand_q;
    acc_hi_d  = acc_hi_q;
    mplr_lo_d = mplr_lo_q;
    carry_d   = carry_q;
    cnt_d     = cnt_q;
    product_d = product_q;
`ifdef MUL_SIGNED_EN
    sgn_d     = sgn_q;
    neg_d     = neg_q;
`endif

    case (state_q)
      S_IDLE, S_DONE: begin
        if (i_start) begin
          state_d   = S_ADD;
          mcand_d   = i_multiplicand;
          mplr_lo_d = i_multiplier;
          acc_hi_d  = '0;
          carry_d   = 1'b0;
          cnt_d     = '0;
`ifdef MUL_SIGNED_EN
          sgn_d = i_signed;
          neg_d = i_signed & (i_multiplicand[WIDTH-1] ^ i_multiplier[WIDTH-1]);
          if (i_signed) begin
            mcand_d   = abs_val(i_multiplicand);
            mplr_lo_d = abs_val(i_multiplier);
          end
`endif
        end else begin
          state_d = S_IDLE;
        end
      end

      S_ADD: begin
        acc_hi_d = i_alu_result;
        carry_d  = i_alu_carry;
        state_d  = S_SHIFT;
      end

      S_SHIFT: begin
        // {carry, acc_hi, mplr_lo} >> 1: the ALU carry re-enters at the top.
        acc_hi_d  = {carry_q, acc_hi_q[WIDTH-1:1]};
        mplr_lo_d = {acc_hi_q[0], mplr_lo_q[WIDTH-1:1]};
        carry_d   = 1'b0;
        cnt_d     = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH - 1)) begin
`ifdef MUL_SIGNED_EN
          if (sgn_q) begin
            state_d = S_NEG;
          end else begin
            state_d   = S_DONE;
            product_d = {acc_hi_d, mplr_lo_d};
          end
`else
          state_d   = S_DONE;
          product_d = {acc_hi_d, mplr_lo_d};
`endif
        end else begin
          state_d = S_ADD;
        end
      end

`ifdef MUL_SIGNED_EN
      S_NEG: begin
        // Sign fix-up is done locally; the ALU is only ever used for adds.
        if (neg_q) begin
          {acc_hi_d, mplr_lo_d} = acc_neg;
        end
        state_d   = S_DONE;
        product_d = {acc_hi_d, mplr_lo_d};
      end
`endif

      default: state_d = S_IDLE;
    endcase
  end

`ifdef MUL_SIGNED_EN
  assign o_busy = (state_q == S_ADD) || (state_q == S_SHIFT) || (state_q == S_NEG);
`else
  assign o_busy = (state_q == S_ADD) || (state_q == S_SHIFT);
`endif
  assign o_done    = (state_q == S_DONE);
  assign o_product = product_q;

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// Testbench for alu_mul_sequencer: behavioural ALU, reference products from
// plain integer multiplication, directed cases plus randomized operands with
// random ignored start pulses while busy. Define MUL_SIGNED_EN for the signed
// cases.
module tb_alu_mul_sequencer;

  localparam int W = 16;

  logic             i_clk = 1'b0;
  logic             i_reset;
  logic             i_start;
  logic [W-1:0]     i_multiplicand;
  logic [W-1:0]     i_multiplier;
  logic             i_signed;
  logic             o_busy;
  logic             o_done;
  logic [2*W-1:0]   o_product;
  logic [2:0]       o_alu_op;
  logic [W-1:0]     o_alu_data_1;
  logic [W-1:0]     o_alu_data_2;
  logic [W-1:0]     i_alu_result;
  logic             i_alu_carry;

  int tests = 0;
  int fails = 0;

  alu_mul_sequencer #(.WIDTH(W)) dut (
    .i_clk          (i_clk),
    .i_reset        (i_reset),
    .i_start        (i_start),
    .i_multiplicand (i_multiplicand),
    .i_multiplier   (i_multiplier),
`ifdef MUL_SIGNED_EN
    .i_signed       (i_signed),
`endif
    .o_busy         (o_busy),
    .o_done         (o_done),
    .o_product      (o_product),
    .o_alu_op       (o_alu_op),
    .o_alu_data_1   (o_alu_data_1),
    .o_alu_data_2   (o_alu_data_2),
    .i_alu_result   (i_alu_result),
    .i_alu_carry    (i_alu_carry)
  );

  always #5 i_clk = ~i_clk;

  // Behavioural execute-stage ALU: only ADD produces a sum.
  always_comb begin
    {i_alu_carry, i_alu_result} = {1'b0, o_alu_data_1} + {1'b0, o_alu_data_2};
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference product from plain arithmetic on the operands.
  function automatic logic [2*W-1:0] ref_product(input logic [W-1:0] a, input logic [W-1:0] b,
                                                 input logic sgn);
    longint sa, sb;
    if (sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'({48'd0, a});
      sb = longint'({48'd0, b});
    end
    return (2*W)'(sa * sb);
  endfunction

  function automatic logic [W-1:0] mag(input logic [W-1:0] x, input logic sgn);
    return (sgn && x[W-1]) ? W'(-x) : x;
  endfunction

  // Present a start for one edge; returns #1 after the accepting edge.
  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sgn);
    i_multiplicand = a;
    i_multiplier   = b;
    i_signed       = sgn;
    i_start        = 1'b1;
    @(posedge i_clk);
    #1;
    i_start = 1'b0;
  endtask

  // Follow one multiply to its o_done pulse and check latency, busy, ALU use
  // and product. noise: random ignored starts/operand churn while busy.
  // pulse_at: cycle index at which a start with A=1,B=1 is pulsed (0 = never).
  task automatic wait_done(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic sgn, input bit noise, input int pulse_at);
    int idx = 1;
    int busy_cnt = 0;
    int adds = 0;
    int bad_alu = 0;
    bit sgn_eff;
    int exp_lat;
    logic [W-1:0] m;
`ifdef MUL_SIGNED_EN
    sgn_eff = sgn;
`else
    sgn_eff = 1'b0;
`endif
    exp_lat = sgn_eff ? 2*W + 2 : 2*W + 1;
    m = mag(a, sgn_eff);
    while (!o_done && idx < 4*W + 10) begin
      if (o_busy) busy_cnt++;
      if (o_alu_op == 3'b010) begin
        adds++;
        if (o_alu_data_2 !== '0 && o_alu_data_2 !== m) bad_alu++;
      end else if (o_alu_op !== 3'b000 || o_alu_data_1 !== '0 || o_alu_data_2 !== '0) begin
        bad_alu++;
      end
      if (idx == pulse_at) begin
        i_start = 1'b1;
        i_multiplicand = 1;
        i_multiplier = 1;
      end else if (noise) begin
        i_start = ($urandom_range(0, 3) == 0);
        i_multiplicand = W'($urandom);
        i_multiplier = W'($urandom);
        i_signed = 1'($urandom);
      end else begin
        i_start = 1'b0;
      end
      @(posedge i_clk);
      #1;
      idx++;
    end
    i_start = 1'b0;
    check({tag, "_done"}, 64'(o_done), 64'd1);
    check({tag, "_lat"}, 64'(idx), 64'(exp_lat));
    check({tag, "_busy_cycles"}, 64'(busy_cnt), 64'(exp_lat - 1));
    check({tag, "_alu_adds"}, 64'(adds), 64'(W));
    check({tag, "_alu_bus"}, 64'(bad_alu), 64'd0);
    check({tag, "_busy_in_done"}, 64'(o_busy), 64'd0);
    check({tag, "_product"}, 64'(o_product), 64'(ref_product(a, b, sgn_eff)));
  endtask

  // One cycle after o_done with no start: idle, no repeat pulse, product held.
  task automatic check_idle_after(input string tag, input logic [2*W-1:0] exp_p);
    @(posedge i_clk);
    #1;
    check({tag, "_no_second_done"}, 64'(o_done), 64'd0);
    check({tag, "_idle"}, 64'(o_busy), 64'd0);
    check({tag, "_held"}, 64'(o_product), 64'(exp_p));
  endtask

  initial begin
    logic [W-1:0] a, b;
    logic s;
    i_reset = 1'b1;
    i_start = 1'b0;
    i_multiplicand = '0;
    i_multiplier = '0;
    i_signed = 1'b0;

    // T1: reset state
    repeat (2) @(posedge i_clk);
    #1;
    check("t1_busy", 64'(o_busy), 64'd0);
    check("t1_done", 64'(o_done), 64'd0);
    check("t1_product", 64'(o_product), 64'd0);
    check("t1_alu_op", 64'(o_alu_op), 64'd0);
    check("t1_alu_d1", 64'(o_alu_data_1), 64'd0);
    check("t1_alu_d2", 64'(o_alu_data_2), 64'd0);
    i_reset = 1'b0;
    @(posedge i_clk);
    #1;

    // T2: small operands
    start_op(16'd3, 16'd5, 1'b0);
    wait_done("t2", 16'd3, 16'd5, 1'b0, 1'b0, 0);
    check("t2_value", 64'(o_product), 64'h0000000F);
    check_idle_after("t2", 32'h0000000F);

    // T3: all-ones operands exercise the ALU carry on every add
    start_op(16'hFFFF, 16'hFFFF, 1'b0);
    wait_done("t3", 16'hFFFF, 16'hFFFF, 1'b0, 1'b0, 0);
    check("t3_value", 64'(o_product), 64'hFFFE0001);
    check_idle_after("t3", 32'hFFFE0001);

    // T4: start pulse while busy is ignored
    start_op(16'd7, 16'd9, 1'b0);
    wait_done("t4", 16'd7, 16'd9, 1'b0, 1'b0, 10);
    check("t4_value", 64'(o_product), 64'h0000003F);
    check_idle_after("t4", 32'h0000003F);

    // T5: reset mid-operation aborts, then a fresh multiply works
    start_op(16'd100, 16'd200, 1'b0);
    repeat (11) @(posedge i_clk);
    i_reset = 1'b1;
    @(posedge i_clk);
    #1;
    i_reset = 1'b0;
    check("t5_abort_busy", 64'(o_busy), 64'd0);
    check("t5_abort_done", 64'(o_done), 64'd0);
    check("t5_abort_product", 64'(o_product), 64'd0);
    begin
      int seen_done = 0;
      for (int i = 0; i < 2*W + 4; i++) begin
        @(posedge i_clk);
        #1;
        if (o_done || o_busy) seen_done++;
      end
      check("t5_stays_idle", 64'(seen_done), 64'd0);
    end
    start_op(16'd2, 16'd3, 1'b0);
    wait_done("t5", 16'd2, 16'd3, 1'b0, 1'b0, 0);
    check("t5_value", 64'(o_product), 64'd6);

    // Back-to-back unsigned: start issued in the DONE cycle
    start_op(16'hABCD, 16'h1234, 1'b0);
    wait_done("b2b", 16'hABCD, 16'h1234, 1'b0, 1'b0, 0);
    check_idle_after("b2b", ref_product(16'hABCD, 16'h1234, 1'b0));

`ifdef MUL_SIGNED_EN
    // T6: signed, then back-to-back most-negative squared
    start_op(16'hFFFD, 16'd5, 1'b1);
    wait_done("t6a", 16'hFFFD, 16'd5, 1'b1, 1'b0, 0);
    check("t6a_value", 64'(o_product), 64'hFFFFFFF1);
    start_op(16'h8000, 16'h8000, 1'b1);
    wait_done("t6b", 16'h8000, 16'h8000, 1'b1, 1'b0, 0);
    check("t6b_value", 64'(o_product), 64'h40000000);
    check_idle_after("t6b", 32'h40000000);
`endif

    // Randomized operands with random ignored starts; every other run is
    // issued back-to-back from the DONE cycle.
    for (int n = 0; n < 12; n++) begin
      a = W'($urandom);
      b = W'($urandom);
      if (n % 4 == 0) a[W-1] = 1'b1;
`ifdef MUL_SIGNED_EN
      s = 1'($urandom);
`else
      s = 1'b0;
`endif
      start_op(a, b, s);
      wait_done($sformatf("rnd%0d", n), a, b, s, 1'b1, 0);
      if (n % 2 == 1) check_idle_after($sformatf("rnd%0d", n), o_product);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
